gate_gpio_exp_sched: RTL and testbench

- Scheduler that sequences all register writes to the gate-driver GPIO expander (I2C dev 0xE8) and shares one byte-write I2C engine between three requesters:
  - the power-up init sequence;
  - a host register-write port;
  - change-driven updates of gate_gpio_data.
- Sits between the gate control logic and the I2C write engine.
- Issues one (dev, reg, data) command at a time, with retry, timeout and an inter-transaction gap.

---
 rtl/gate_gpio_exp_pkg.sv | 26 ++
 rtl/gate_gpio_exp_timer.sv | 26 ++
 rtl/gate_gpio_exp_sched.sv | 229 ++++++++++++++++++++++
 tb/tb_gate_gpio_exp_sched.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_gpio_exp_pkg.sv
// Shared types and register map for the gate-driver GPIO expander scheduler.
package gate_gpio_exp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_t;

    typedef enum logic [1:0] {
        REQ_INIT,
        REQ_HOST,
        REQ_LO,
        REQ_HI
    } req_t;

    localparam logic [7:0] REG_OUT0     = 8'h02;
    localparam logic [7:0] REG_OUT1     = 8'h03;
    localparam logic [7:0] REG_CFG0     = 8'h06;
    localparam logic [7:0] REG_CFG1     = 8'h07;
    localparam logic [7:0] DEV_ADDR_DEF = 8'hE8;

    localparam int unsigned TMR_W = 32;

endpackage

// File: rtl/gate_gpio_exp_timer.sv
// Loadable down-counter shared by the inter-transaction gap and the done timeout.
module gate_gpio_exp_timer
    import gate_gpio_exp_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_value,
    output logic             o_expired
);

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/gate_gpio_exp_sched.sv
// Serialises init, host and gpio-change register writes onto one I2C byte-write engine.
module gate_gpio_exp_sched
    import gate_gpio_exp_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR    = DEV_ADDR_DEF,
    parameter int unsigned GAP_CYC     = 50000,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic        s_clk_25mhz,
    input  logic        s_reset,
    input  logic [15:0] gate_gpio_data,
    input  logic        init_req,
    input  logic        host_req,
    input  logic [7:0]  host_reg,
    input  logic [7:0]  host_data,
    output logic        host_ack,
    output logic        host_err,
    output logic        i2c_cmd_valid,
    input  logic        i2c_cmd_ready,
    output logic [7:0]  i2c_dev_addr,
    output logic [7:0]  i2c_reg_addr,
    output logic [7:0]  i2c_wr_data,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    input  logic        err_clr,
    output logic        busy,
    output logic        init_done,
    output logic        err_sticky,
    output logic [7:0]  nack_count
);

    localparam logic [TMR_W-1:0] LP_GAP_LD    = GAP_CYC - 1;
    localparam logic [TMR_W-1:0] LP_TO_LD     = TIMEOUT_CYC - 1;
    localparam logic [7:0]       LP_MAX_RETRY = 8'(MAX_RETRY);

    state_t     r_state;
    req_t       r_req;
    logic [7:0] r_cmd_reg;
    logic [7:0] r_cmd_data;
    logic [7:0] r_shadow_lo;
    logic [7:0] r_shadow_hi;
    logic [1:0] r_init_step;
    logic       r_init_pending;
    logic       r_init_done;
    logic       r_stale;
    logic [7:0] r_retry;
    logic       r_host_ack;
    logic       r_host_err;
    logic       r_err_sticky;
    logic [7:0] r_nack_count;

    logic             w_lo_pend;
    logic             w_hi_pend;
    logic             w_arb;
    req_t             w_req;
    logic [7:0]       w_reg;
    logic [7:0]       w_data;
    logic             w_accept;
    logic             w_ok;
    logic             w_fail;
    logic             w_exhaust;
    logic             w_finish;
    logic             w_stale;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_exp;

    assign w_lo_pend = r_init_done && (gate_gpio_data[7:0] != r_shadow_lo);
    assign w_hi_pend = r_init_done && (gate_gpio_data[15:8] != r_shadow_hi);

    // Fixed priority: init, then host (only once init is done), then lo, then hi.
    always_comb begin
        w_arb  = 1'b1;
        w_req  = REQ_INIT;
        w_reg  = REG_CFG0;
        w_data = 8'h00;
        if (r_init_pending) begin
            case (r_init_step)
                2'd0: w_reg = REG_CFG0;
                2'd1: w_reg = REG_CFG1;
                2'd2: begin
                    w_reg  = REG_OUT0;
                    w_data = gate_gpio_data[7:0];
                end
                default: begin
                    w_reg  = REG_OUT1;
                    w_data = gate_gpio_data[15:8];
                end
            endcase
        end else if (host_req && r_init_done) begin
            w_req  = REQ_HOST;
            w_reg  = host_reg;
            w_data = host_data;
        end else if (w_lo_pend) begin
            w_req  = REQ_LO;
            w_reg  = REG_OUT0;
            w_data = gate_gpio_data[7:0];
        end else if (w_hi_pend) begin
            w_req  = REQ_HI;
            w_reg  = REG_OUT1;
            w_data = gate_gpio_data[15:8];
        end else begin
            w_arb = 1'b0;
        end
    end

    assign w_accept   = (r_state == S_ISSUE) && i2c_cmd_ready;
    assign w_ok       = (r_state == S_WAIT) && i2c_done && !i2c_nack;
    assign w_fail     = (r_state == S_WAIT) && (i2c_done ? i2c_nack : w_tmr_exp);
    assign w_exhaust  = w_fail && (r_retry >= LP_MAX_RETRY);
    assign w_finish   = w_ok || w_exhaust;
    assign w_stale    = r_stale || init_req;
    assign w_tmr_load = w_accept || w_ok || w_fail;
    assign w_tmr_val  = w_accept ? LP_TO_LD : LP_GAP_LD;

    gate_gpio_exp_timer u_timer (
        .i_clk     (s_clk_25mhz),
        .i_rst     (s_reset),
        .i_load    (w_tmr_load),
        .i_value   (w_tmr_val),
        .o_expired (w_tmr_exp)
    );

    always_ff @(posedge s_clk_25mhz or posedge s_reset) begin
        if (s_reset) begin
            r_state    <= S_IDLE;
            r_req      <= REQ_INIT;
            r_cmd_reg  <= '0;
            r_cmd_data <= '0;
            r_retry    <= '0;
            r_stale    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_arb) begin
                        r_state    <= S_ISSUE;
                        r_req      <= w_req;
                        r_cmd_reg  <= w_reg;
                        r_cmd_data <= w_data;
                        r_stale    <= init_req;
                    end
                end
                S_ISSUE: begin
                    if (w_accept) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_ok || w_fail) begin
                        r_state <= S_GAP;
                        r_retry <= (w_fail && !w_exhaust) ? r_retry + 8'd1 : 8'd0;
                    end
                end
                default: begin
                    if (w_tmr_exp) r_state <= (r_retry != 8'd0) ? S_ISSUE : S_IDLE;
                end
            endcase
            // A re-init while a command is latched voids that command's bookkeeping.
            if (init_req && (r_state != S_IDLE)) r_stale <= 1'b1;
        end
    end

    always_ff @(posedge s_clk_25mhz or posedge s_reset) begin
        if (s_reset) begin
            r_shadow_lo    <= '0;
            r_shadow_hi    <= '0;
            r_init_step    <= '0;
            r_init_pending <= 1'b1;
            r_init_done    <= 1'b0;
            r_host_ack     <= 1'b0;
            r_host_err     <= 1'b0;
            r_err_sticky   <= 1'b0;
            r_nack_count   <= '0;
        end else begin
            r_host_ack <= 1'b0;
            if (w_fail && (r_nack_count != 8'hFF)) r_nack_count <= r_nack_count + 8'd1;
            if (w_finish) begin
                case (r_req)
                    REQ_INIT: begin
                        if (!w_stale) begin
                            if (w_exhaust) begin
                                r_init_step <= 2'd0;
                            end else begin
                                r_init_step <= r_init_step + 2'd1;
                                if (r_init_step == 2'd2) r_shadow_lo <= r_cmd_data;
                                if (r_init_step == 2'd3) begin
                                    r_shadow_hi    <= r_cmd_data;
                                    r_init_pending <= 1'b0;
                                    r_init_done    <= 1'b1;
                                end
                            end
                        end
                    end
                    REQ_HOST: begin
                        r_host_ack <= 1'b1;
                        r_host_err <= w_exhaust;
                    end
                    REQ_LO: begin
                        if (!w_stale) r_shadow_lo <= r_cmd_data;
                    end
                    default: begin
                        if (!w_stale) r_shadow_hi <= r_cmd_data;
                    end
                endcase
            end
            if (init_req) begin
                r_init_pending <= 1'b1;
                r_init_step    <= 2'd0;
                r_init_done    <= 1'b0;
            end
            if (w_exhaust) begin
                r_err_sticky <= 1'b1;
            end else if (err_clr) begin
                r_err_sticky <= 1'b0;
            end
        end
    end

    assign host_ack      = r_host_ack;
    assign host_err      = r_host_err;
    assign i2c_cmd_valid = (r_state == S_ISSUE);
    assign i2c_dev_addr  = DEV_ADDR;
    assign i2c_reg_addr  = r_cmd_reg;
    assign i2c_wr_data   = r_cmd_data;
    assign busy          = (r_state != S_IDLE);
    assign init_done     = r_init_done;
    assign err_sticky    = r_err_sticky;
    assign nack_count    = r_nack_count;

endmodule

// File: tb/tb_gate_gpio_exp_sched.sv
// Scoreboard bench: expected I2C commands queued with stimulus, checked at engine accept.
module tb_gate_gpio_exp_sched;

    localparam int GAP  = 20;
    localparam int TOUT = 40;
    localparam int DLY  = 10;

    logic        clk = 1'b0;
    logic        s_reset;
    logic [15:0] gate_gpio_data;
    logic        init_req;
    logic        host_req;
    logic [7:0]  host_reg;
    logic [7:0]  host_data;
    logic        host_ack;
    logic        host_err;
    logic        i2c_cmd_valid;
    logic        i2c_cmd_ready;
    logic [7:0]  i2c_dev_addr;
    logic [7:0]  i2c_reg_addr;
    logic [7:0]  i2c_wr_data;
    logic        i2c_done;
    logic        i2c_nack;
    logic        err_clr;
    logic        busy;
    logic        init_done;
    logic        err_sticky;
    logic [7:0]  nack_count;

    gate_gpio_exp_sched #(
        .DEV_ADDR    (8'hE8),
        .GAP_CYC     (GAP),
        .TIMEOUT_CYC (TOUT),
        .MAX_RETRY   (3)
    ) dut (
        .s_clk_25mhz    (clk),
        .s_reset        (s_reset),
        .gate_gpio_data (gate_gpio_data),
        .init_req       (init_req),
        .host_req       (host_req),
        .host_reg       (host_reg),
        .host_data      (host_data),
        .host_ack       (host_ack),
        .host_err       (host_err),
        .i2c_cmd_valid  (i2c_cmd_valid),
        .i2c_cmd_ready  (i2c_cmd_ready),
        .i2c_dev_addr   (i2c_dev_addr),
        .i2c_reg_addr   (i2c_reg_addr),
        .i2c_wr_data    (i2c_wr_data),
        .i2c_done       (i2c_done),
        .i2c_nack       (i2c_nack),
        .err_clr        (err_clr),
        .busy           (busy),
        .init_done      (init_done),
        .err_sticky     (err_sticky),
        .nack_count     (nack_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic [7:0] d;
    } cmd_t;

    typedef struct {
        logic [15:0] gpio;
        int          n_wr;
    } vec_t;

    cmd_t expq[$];
    vec_t vecs[5];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int n_acc = 0;
    int acc_last = 0;
    int last_end = 0;
    bit have_end = 0;
    bit eng_nack = 0;
    bit eng_hang = 0;
    logic [7:0] m_lo;
    logic [7:0] m_hi;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    task automatic push(input logic [7:0] r, input logic [7:0] d);
        cmd_t c;
        c.r = r;
        c.d = d;
        expq.push_back(c);
    endtask

    task automatic push_init(input logic [15:0] g);
        push(8'h06, 8'h00);
        push(8'h07, 8'h00);
        push(8'h02, g[7:0]);
        push(8'h03, g[15:8]);
    endtask

    task automatic wait_quiet(input int budget, input string nm);
        int q = 0;
        int k = 0;
        while (q < 5 && k < budget) begin
            @(negedge clk);
            k++;
            q = busy ? 0 : q + 1;
        end
        if (q < 5) begin
            n_chk++;
            $display("FAIL %s_idle: busy=%0b after %0d cycles, required idle", nm, busy, budget);
        end
    endtask

    task automatic wait_acc(input int target, input int budget, input string nm);
        int k = 0;
        while (n_acc < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_acc < target) begin
            n_chk++;
            $display("FAIL %s_accept: got %0d accepts, required %0d", nm, n_acc, target);
        end
    endtask

    task automatic wait_ack(input int budget, output bit got, output bit err);
        got = 0;
        err = 0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (host_ack) begin
                got = 1;
                err = host_err;
                host_req = 1'b0;
            end
        end
    endtask

    // I2C engine model: always ready, done DLY cycles after accept
    initial begin : engine
        cmd_t e;
        bit   pend;
        int   dcnt;
        pend = 0;
        dcnt = 0;
        i2c_cmd_ready = 1'b1;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            if (s_reset) begin
                pend = 0;
                have_end = 0;
            end else begin
                if (pend) begin
                    if (dcnt == 0) begin
                        i2c_done = 1'b1;
                        i2c_nack = eng_nack;
                        pend = 0;
                        last_end = cyc;
                        have_end = 1;
                    end else begin
                        dcnt--;
                    end
                end
                if (i2c_cmd_valid && i2c_cmd_ready) begin
                    n_acc++;
                    acc_last = cyc;
                    if (expq.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_cmd: got reg %02h data %02h, required none",
                                 i2c_reg_addr, i2c_wr_data);
                    end else begin
                        e = expq.pop_front();
                        chk("cmd_dev", i2c_dev_addr, 8'hE8);
                        chk("cmd_reg", i2c_reg_addr, e.r);
                        chk("cmd_data", i2c_wr_data, e.d);
                    end
                    if (have_end) chk("cmd_gap", (cyc - last_end >= GAP) ? 1 : 0, 1);
                    if (!eng_hang) begin
                        pend = 1;
                        dcnt = DLY - 1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit got;
        bit err;
        int a0;
        int t1;
        s_reset = 1'b1;
        gate_gpio_data = 16'h0000;
        init_req = 1'b0;
        host_req = 1'b0;
        host_reg = 8'h00;
        host_data = 8'h00;
        err_clr = 1'b0;

        vecs[0] = '{16'h00A5, 1};
        vecs[1] = '{16'h5A5A, 2};
        vecs[2] = '{16'h5A5A, 0};
        vecs[3] = '{16'hFF5A, 1};
        vecs[4] = '{16'h0000, 2};

        repeat (3) @(negedge clk);
        chk("rst_valid", i2c_cmd_valid, 0);
        chk("rst_dev", i2c_dev_addr, 8'hE8);
        chk("rst_busy", busy, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_err", err_sticky, 0);
        chk("rst_nack", nack_count, 0);
        chk("rst_ack", host_ack, 0);

        push_init(16'h0000);
        m_lo = 8'h00;
        m_hi = 8'h00;
        s_reset = 1'b0;
        wait_quiet(1000, "init");
        chk("init_done", init_done, 1);
        chk("init_writes", n_acc, 4);
        chk("init_q_empty", expq.size(), 0);

        for (int i = 0; i < 5; i++) begin
            a0 = n_acc;
            if (vecs[i].gpio[7:0] != m_lo) push(8'h02, vecs[i].gpio[7:0]);
            if (vecs[i].gpio[15:8] != m_hi) push(8'h03, vecs[i].gpio[15:8]);
            m_lo = vecs[i].gpio[7:0];
            m_hi = vecs[i].gpio[15:8];
            gate_gpio_data = vecs[i].gpio;
            wait_quiet(400, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_writes", i), n_acc - a0, vecs[i].n_wr);
            chk($sformatf("vec%0d_q_empty", i), expq.size(), 0);
        end

        push(8'h06, 8'hFF);
        push(8'h03, 8'hC3);
        host_reg = 8'h06;
        host_data = 8'hFF;
        host_req = 1'b1;
        gate_gpio_data = 16'hC300;
        wait_ack(400, got, err);
        chk("host_ack_seen", got, 1);
        chk("host_err_ok", err, 0);
        wait_quiet(400, "host");
        chk("host_q_empty", expq.size(), 0);

        eng_nack = 1;
        repeat (4) push(8'h06, 8'h11);
        host_data = 8'h11;
        host_req = 1'b1;
        wait_ack(800, got, err);
        chk("nack_ack_seen", got, 1);
        chk("nack_host_err", err, 1);
        chk("nack_count4", nack_count, 4);
        wait_quiet(400, "nack");
        chk("nack_q_empty", expq.size(), 0);
        chk("sticky_set", err_sticky, 1);
        eng_nack = 0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("sticky_clr", err_sticky, 0);

        eng_hang = 1;
        a0 = n_acc;
        push(8'h02, 8'h77);
        push(8'h02, 8'h77);
        gate_gpio_data = 16'hC377;
        wait_acc(a0 + 1, 100, "to_first");
        t1 = acc_last;
        wait_acc(a0 + 2, 300, "to_retry");
        chk("to_spacing", acc_last - t1, TOUT + GAP + 1);
        chk("to_nack_count", nack_count, 5);
        chk("to_q_empty", expq.size(), 0);
        repeat (5) @(negedge clk);
        #2 s_reset = 1'b1;
        #1;
        chk("arst_valid", i2c_cmd_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_nack", nack_count, 0);
        chk("arst_init_done", init_done, 0);
        @(negedge clk);
        eng_hang = 0;
        a0 = n_acc;
        push_init(16'hC377);
        m_lo = 8'h77;
        m_hi = 8'hC3;
        s_reset = 1'b0;
        wait_quiet(1000, "reinit");
        chk("reinit_done", init_done, 1);
        chk("reinit_writes", n_acc - a0, 4);
        chk("reinit_q_empty", expq.size(), 0);

        a0 = n_acc;
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        chk("ireq_clears_done", init_done, 0);
        gate_gpio_data = 16'h1E2D;
        push_init(16'h1E2D);
        wait_quiet(1000, "ireq");
        chk("ireq_done", init_done, 1);
        chk("ireq_writes", n_acc - a0, 4);
        chk("ireq_q_empty", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
